// File: rtl/exu_pkg.sv
// -----------------------------------------------------------------------------
// exu_pkg
//   Shared types and constants for the EXU operand stage.
//   - spec_inst_e : special-instruction code carried alongside a decoded op
//   - REG_IDX_W   : architectural register index width
//   - src1_used() : whether rs1 feeds the ALU for a given decode
// -----------------------------------------------------------------------------
package exu_pkg;

   localparam int REG_IDX_W = 5;

   typedef enum logic [2:0] {
      NONE  = 3'd0,
      JAL   = 3'd1,
      JALR  = 3'd2,
      AUIPC = 3'd3,
      LUI   = 3'd4,
      STORE = 3'd5
   } spec_inst_e;

   // JALR reads rs1 for its target even when the decoder leaves ers1 clear.
   function automatic logic src1_used(input logic ers1, input logic [2:0] specinst);
      return ers1 || (specinst == JALR);
   endfunction

endpackage

// File: rtl/exu_operand_stage_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
//   Priority bypass match for one source operand over NUM_FWD channels.
//   Channel 0 is the youngest producer and wins over higher channels.
//   Register x0 never matches.
// Ports
//   idx_i          source register index
//   rf_data_i      regfile value, used when no channel matches
//   fwd_valid_i    per-channel pending rd write
//   fwd_pending_i  per-channel "value not ready yet"
//   fwd_rd_i       per-channel destination index, packed
//   fwd_data_i     per-channel result, packed
//   value_o        resolved operand value
//   hit_o          some channel matched
//   pending_o      matching channel's value is not ready
// -----------------------------------------------------------------------------
module fwd_select
   import exu_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_FWD    = 2
) (
   input  logic [REG_IDX_W-1:0]          idx_i,
   input  logic [DATA_WIDTH-1:0]         rf_data_i,
   input  logic [NUM_FWD-1:0]            fwd_valid_i,
   input  logic [NUM_FWD-1:0]            fwd_pending_i,
   input  logic [NUM_FWD*REG_IDX_W-1:0]  fwd_rd_i,
   input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data_i,
   output logic [DATA_WIDTH-1:0]         value_o,
   output logic                          hit_o,
   output logic                          pending_o
);

   always_comb begin
      // NOTE: every output gets a default before any conditional write, so no latch is inferred.
      value_o   = rf_data_i;
      hit_o     = 1'b0;
      pending_o = 1'b0;
      // Walk from the oldest channel down to channel 0 so the youngest match is written last.
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
         if (fwd_valid_i[k] && (fwd_rd_i[k*REG_IDX_W +: REG_IDX_W] == idx_i) && (idx_i != '0)) begin
            value_o   = fwd_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            hit_o     = 1'b1;
            pending_o = fwd_pending_i[k];
         end
      end
   end

endmodule

// File: rtl/exu_operand_stage.sv
// -----------------------------------------------------------------------------
// exu_operand_stage
//   Registered operand stage between ID and the ALU. Accepts a decoded
//   instruction on a valid/ready handshake, resolves rs1/rs2 through the bypass
//   channels, stalls on a used source whose producer is still pending, and
//   presents registered ALU operands, store data and pc one cycle later.
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   in_valid_i / in_ready_o        input handshake (in_ready_o is combinational)
//   ers1_i, ers2_i, specinst_i     decode controls
//   rs1_idx_i, rs2_idx_i           source indices
//   rs1_i, rs2_i, pc_i, imme_i     regfile values, pc, immediate
//   fwd_*_i                        bypass channels, channel 0 youngest
//   flush_i                        squash held and incoming instruction
//   out_valid_o / out_ready_i      output handshake
//   alu_A_o, alu_B_o               ALU operands
//   store_data_o, pc_o, specinst_o held instruction's rs2', pc, spec code
//   stall_cnt_o                    saturating count of hazard-stall cycles
// -----------------------------------------------------------------------------
module exu_operand_stage
   import exu_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_FWD    = 2,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic                          ers1_i,
   input  logic                          ers2_i,
   input  logic [2:0]                    specinst_i,
   input  logic [4:0]                    rs1_idx_i,
   input  logic [4:0]                    rs2_idx_i,
   input  logic [DATA_WIDTH-1:0]         rs1_i,
   input  logic [DATA_WIDTH-1:0]         rs2_i,
   input  logic [DATA_WIDTH-1:0]         pc_i,
   input  logic [DATA_WIDTH-1:0]         imme_i,
   input  logic [NUM_FWD-1:0]            fwd_valid_i,
   input  logic [NUM_FWD-1:0]            fwd_pending_i,
   input  logic [NUM_FWD*5-1:0]          fwd_rd_i,
   input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data_i,
   input  logic                          flush_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [DATA_WIDTH-1:0]         alu_A_o,
   output logic [DATA_WIDTH-1:0]         alu_B_o,
   output logic [DATA_WIDTH-1:0]         store_data_o,
   output logic [DATA_WIDTH-1:0]         pc_o,
   output logic [2:0]                    specinst_o,
   output logic [CNT_WIDTH-1:0]          stall_cnt_o
);

   // ---------------------------------------------------------------- bypass
   logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
   logic                  rs1_hit, rs2_hit;
   logic                  rs1_pend, rs2_pend;

   fwd_select #(.DATA_WIDTH(DATA_WIDTH), .NUM_FWD(NUM_FWD)) u_fwd_rs1 (
      .idx_i         (rs1_idx_i),
      .rf_data_i     (rs1_i),
      .fwd_valid_i   (fwd_valid_i),
      .fwd_pending_i (fwd_pending_i),
      .fwd_rd_i      (fwd_rd_i),
      .fwd_data_i    (fwd_data_i),
      .value_o       (rs1_val),
      .hit_o         (rs1_hit),
      .pending_o     (rs1_pend)
   );

   fwd_select #(.DATA_WIDTH(DATA_WIDTH), .NUM_FWD(NUM_FWD)) u_fwd_rs2 (
      .idx_i         (rs2_idx_i),
      .rf_data_i     (rs2_i),
      .fwd_valid_i   (fwd_valid_i),
      .fwd_pending_i (fwd_pending_i),
      .fwd_rd_i      (fwd_rd_i),
      .fwd_data_i    (fwd_data_i),
      .value_o       (rs2_val),
      .hit_o         (rs2_hit),
      .pending_o     (rs2_pend)
   );

   // ------------------------------------------------------ hazard/handshake
   logic rs1_used, rs2_used, hazard, capture;

   assign rs1_used = src1_used(ers1_i, specinst_i);
   assign rs2_used = ers2_i;
   // A source only stalls if it is actually consumed and its producer is a load in flight.
   assign hazard   = (rs1_used && rs1_hit && rs1_pend) || (rs2_used && rs2_hit && rs2_pend);

   logic out_valid_q, out_valid_d;

   assign in_ready_o = (!out_valid_q || out_ready_i) && !hazard;
   assign capture    = in_valid_i && in_ready_o && !flush_i;

   // ----------------------------------------------------------- operand mux
   logic [DATA_WIDTH-1:0] op_a, op_b;

   always_comb begin
      op_a = '0;
      if (ers1_i)                                        op_a = rs1_val;
      else if (specinst_i == AUIPC || specinst_i == JAL) op_a = pc_i;
      else if (specinst_i == JALR)                       op_a = rs1_val;

      // Stores send the address offset to the ALU; rs2 travels as store data.
      if (ers2_i && specinst_i == STORE) op_b = imme_i;
      else if (ers2_i)                   op_b = rs2_val;
      else                               op_b = imme_i;
   end

   // ------------------------------------------------------ next-state logic
   logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
   logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
   logic [DATA_WIDTH-1:0] store_data_q, store_data_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [2:0]            specinst_q, specinst_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;

   always_comb begin
      out_valid_d  = out_valid_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      store_data_d = store_data_q;
      pc_d         = pc_q;
      specinst_d   = specinst_q;
      stall_cnt_d  = stall_cnt_q;

      if (in_valid_i && hazard && !flush_i && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end

      // Flush outranks capture and drain; data registers keep their last value.
      if (flush_i) begin
         out_valid_d = 1'b0;
      end else if (capture) begin
         out_valid_d  = 1'b1;
         alu_a_d      = op_a;
         alu_b_d      = op_b;
         store_data_d = rs2_val;
         pc_d         = pc_i;
         specinst_d   = specinst_i;
      end else if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------- registers
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
      if (rst_i) begin
         // NOTE: the output registers are plain flops (no memory array), so every one is reset.
         out_valid_q  <= 1'b0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         store_data_q <= '0;
         pc_q         <= '0;
         specinst_q   <= NONE;
         stall_cnt_q  <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         store_data_q <= store_data_d;
         pc_q         <= pc_d;
         specinst_q   <= specinst_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign alu_A_o      = alu_a_q;
   assign alu_B_o      = alu_b_q;
   assign store_data_o = store_data_q;
   assign pc_o         = pc_q;
   assign specinst_o   = specinst_q;
   assign stall_cnt_o  = stall_cnt_q;

endmodule
